mux4to1_rr: RTL and testbench



---
 rtl/mux4to1_rr.sv | 116 +++++++++++
 tb/tb_mux4to1_rr.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux4to1_rr.sv
// 4:1 valid/ready merge with packet-aware round-robin arbitration.
// Registered output tagged with the source index for a downstream demux.
module mux4to1_rr #(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      in_valid,
  input  logic [4*DW-1:0] in_data,
  input  logic [3:0]      in_last,
  output logic [3:0]      in_ready,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic            out_last,
  output logic [1:0]      out_sel,
  input  logic            out_ready,
  output logic            busy
);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t     state, state_n;
  logic [1:0] owner, owner_n;
  logic [1:0] rr_ptr, rr_n;

  logic          load;
  logic          gnt_vld;
  logic [1:0]    gnt_idx;
  logic          xfer;
  logic          gnt_last;
  logic [DW-1:0] gnt_data;

  assign load = !out_valid | out_ready;

  // Scan from highest to lowest priority offset; the lowest offset
  // (rr_ptr+1) is written last, so it wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = rr_ptr;
    if (state == LOCKED) begin
      gnt_vld = 1'b1;
      gnt_idx = owner;
    end else begin
      for (int k = 3; k >= 0; k--) begin
        if (in_valid[2'(rr_ptr + 2'(k) + 2'd1)]) begin
          gnt_vld = 1'b1;
          gnt_idx = 2'(rr_ptr + 2'(k) + 2'd1);
        end
      end
    end
  end

  assign gnt_data = in_data[gnt_idx*DW +: DW];
  assign gnt_last = in_last[gnt_idx];
  assign xfer     = load & gnt_vld & in_valid[gnt_idx];
  assign in_ready = (load & gnt_vld) ? (4'b0001 << gnt_idx)
                                     : 4'b0000;
  assign busy     = (state == LOCKED);

  always_comb begin
    state_n = state;
    owner_n = owner;
    rr_n    = rr_ptr;
    if (xfer) begin
      unique case (state)
        IDLE: begin
          if (gnt_last) begin
            rr_n = gnt_idx;
          end else begin
            state_n = LOCKED;
            owner_n = gnt_idx;
          end
        end
        LOCKED: begin
          if (gnt_last) begin
            state_n = IDLE;
            rr_n    = owner;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      owner  <= 2'd0;
      rr_ptr <= 2'd3;
    end else begin
      state  <= state_n;
      owner  <= owner_n;
      rr_ptr <= rr_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= 2'd0;
    end else if (load) begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= gnt_data;
        out_last <= gnt_last;
        out_sel  <= gnt_idx;
      end
    end
  end

endmodule

// File: tb/tb_mux4to1_rr.sv
// Directed bench for mux4to1_rr: arbitration order, locking,
// backpressure, stalls and reset mid-packet.
module tb_mux4to1_rr;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    in_valid;
  logic [4*DW-1:0] in_data;
  logic [3:0]    in_last;
  logic [3:0]    in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [1:0]    out_sel;
  logic          out_ready;
  logic          busy;

  int npass = 0;
  int ntot  = 0;

  mux4to1_rr #(.DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sel   (out_sel),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ntot++;
    if (obs === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic src(input int i, input logic v,
                     input logic [7:0] d, input logic l);
    in_valid[i]       = v;
    in_data[i*DW +: DW] = d;
    in_last[i]        = l;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    in_last   = '0;
    out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [1:0] s,
                         input logic [7:0] d, input logic l);
    chk({tag, "_v"}, 32'(out_valid), 32'd1);
    chk({tag, "_sel"}, 32'(out_sel), 32'(s));
    chk({tag, "_data"}, 32'(out_data), 32'(d));
    chk({tag, "_last"}, 32'(out_last), 32'(l));
  endtask

  // Source-side protocol monitor: a pending beat must stay put.
  logic [3:0]      p_valid, p_ready, p_last;
  logic [4*DW-1:0] p_data;
  logic            p_rst = 1'b1;

  always @(posedge clk) begin
    if (!rst && !p_rst) begin
      chk("onehot", 32'($countones(in_ready) <= 1), 32'd1);
      for (int i = 0; i < 4; i++) begin
        if (p_valid[i] && !p_ready[i]) begin
          chk("hold_v", 32'(in_valid[i]), 32'd1);
          chk("hold_d", 32'(in_data[i*DW +: DW]),
                        32'(p_data[i*DW +: DW]));
          chk("hold_l", 32'(in_last[i]), 32'(p_last[i]));
        end
      end
    end
    p_valid = in_valid;
    p_ready = in_ready;
    p_data  = in_data;
    p_last  = in_last;
    p_rst   = rst;
  end

  initial begin
    do_reset();
    #1;
    chk("rst_v", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_sel", 32'(out_sel), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);

    // single beat on src2
    out_ready = 1'b1;
    src(2, 1'b1, 8'hA5, 1'b1);
    #1 chk("t1_rdy", 32'(in_ready), 32'b0100);
    tick();
    src(2, 1'b0, 8'h00, 1'b0);
    chk_out("t1", 2'd2, 8'hA5, 1'b1);
    chk("t1_busy", 32'(busy), 32'd0);
    // rr_ptr=2: src3 outranks src1
    src(1, 1'b1, 8'h01, 1'b1);
    src(3, 1'b1, 8'h03, 1'b1);
    #1 chk("t1_rr", 32'(in_ready), 32'b1000);

    // all four single-beat: 0,1,2,3,0
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++)
      src(i, 1'b1, 8'(8'h20 + i), 1'b1);
    for (int k = 0; k < 5; k++) begin
      #1 chk("t2_rdy", 32'(in_ready), 32'(4'b0001 << (k % 4)));
      tick();
      chk_out("t2", 2'(k % 4), 8'(8'h20 + k % 4), 1'b1);
    end

    // 3-beat packet on src1 while src0/src3 wait
    do_reset();
    out_ready = 1'b1;
    src(1, 1'b1, 8'h11, 1'b0);
    src(3, 1'b1, 8'h33, 1'b1);
    #1 chk("t3_rdy0", 32'(in_ready), 32'b0010);
    chk("t3_busy0", 32'(busy), 32'd0);
    tick();
    chk_out("t3_b1", 2'd1, 8'h11, 1'b0);
    chk("t3_busy1", 32'(busy), 32'd1);
    src(0, 1'b1, 8'h30, 1'b1);
    src(1, 1'b1, 8'h12, 1'b0);
    #1 chk("t3_rdy1", 32'(in_ready), 32'b0010);
    tick();
    chk_out("t3_b2", 2'd1, 8'h12, 1'b0);
    chk("t3_busy2", 32'(busy), 32'd1);
    src(1, 1'b1, 8'h13, 1'b1);
    tick();
    chk_out("t3_b3", 2'd1, 8'h13, 1'b1);
    chk("t3_busy3", 32'(busy), 32'd0);
    src(1, 1'b0, 8'h00, 1'b0);
    #1 chk("t3_rdy3", 32'(in_ready), 32'b1000);
    tick();
    chk_out("t3_s3", 2'd3, 8'h33, 1'b1);
    src(3, 1'b0, 8'h00, 1'b0);
    #1 chk("t3_rdy4", 32'(in_ready), 32'b0001);
    tick();
    chk_out("t3_s0", 2'd0, 8'h30, 1'b1);

    // backpressure
    do_reset();
    src(0, 1'b1, 8'h3C, 1'b1);
    #1 chk("t4_rdy0", 32'(in_ready), 32'b0001);
    tick();
    src(0, 1'b1, 8'h3D, 1'b1);
    for (int k = 0; k < 4; k++) begin
      #1 chk("t4_rdy", 32'(in_ready), 32'b0000);
      chk_out("t4_hold", 2'd0, 8'h3C, 1'b1);
      tick();
    end
    out_ready = 1'b1;
    #1 chk("t4_rdy1", 32'(in_ready), 32'b0001);
    tick();
    chk_out("t4_next", 2'd0, 8'h3D, 1'b1);
    src(0, 1'b0, 8'h00, 1'b0);
    tick();
    chk("t4_drain", 32'(out_valid), 32'd0);

    // lock stall on src2
    do_reset();
    out_ready = 1'b1;
    src(2, 1'b1, 8'h51, 1'b0);
    #1 chk("t5_rdy0", 32'(in_ready), 32'b0100);
    tick();
    chk_out("t5_b1", 2'd2, 8'h51, 1'b0);
    src(2, 1'b0, 8'h00, 1'b0);
    src(1, 1'b1, 8'h77, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1 chk("t5_no1", 32'(in_ready[1]), 32'd0);
      tick();
      chk("t5_stall_v", 32'(out_valid), 32'd0);
      chk("t5_busy", 32'(busy), 32'd1);
    end
    src(2, 1'b1, 8'h52, 1'b1);
    tick();
    chk_out("t5_b2", 2'd2, 8'h52, 1'b1);
    chk("t5_busy_end", 32'(busy), 32'd0);
    src(2, 1'b0, 8'h00, 1'b0);
    #1 chk("t5_rdy1", 32'(in_ready), 32'b0010);
    tick();
    chk_out("t5_s1", 2'd1, 8'h77, 1'b1);

    // reset while locked with a held beat
    do_reset();
    src(3, 1'b1, 8'h61, 1'b0);
    #1 chk("t6_rdy0", 32'(in_ready), 32'b1000);
    tick();
    chk("t6_busy", 32'(busy), 32'd1);
    chk_out("t6_b1", 2'd3, 8'h61, 1'b0);
    src(3, 1'b1, 8'h62, 1'b0);
    src(0, 1'b1, 8'h0A, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_v", 32'(out_valid), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    out_ready = 1'b1;
    #1 chk("t6_rdy1", 32'(in_ready), 32'b0001);
    tick();
    chk_out("t6_s0", 2'd0, 8'h0A, 1'b1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
